// File: rtl/alu_execute_stage.sv
// alu_execute_stage: one-cycle execute stage for a small ARM-like core.
// Decodes the ALU control code, performs the ALU operation, computes the
// fall-through and branch target addresses, picks the next PC, and
// registers everything behind a valid qualifier.
module alu_execute_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             branch,
    output logic             out_valid,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] next_pc
);

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_ORR  = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_PASS = 4'b0111;
    localparam logic [3:0] CTL_NOR  = 4'b1100;

    logic [3:0]       ctl_comb;
    logic [WIDTH-1:0] result_comb;
    logic             zero_comb;
    logic [WIDTH-1:0] pc_plus4_comb;
    logic [WIDTH-1:0] target_comb;
    logic [WIDTH-1:0] next_pc_comb;

    // Translate the control unit's operation class plus opcode into an ALU code;
    // unrecognised R-type opcodes and class 11 fall back to ADD.
    always_comb begin
        ctl_comb = CTL_ADD;
        case (alu_op)
            2'b00: ctl_comb = CTL_ADD;
            2'b01: ctl_comb = CTL_PASS;
            2'b10: begin
                case (opcode)
                    OPC_ADD: ctl_comb = CTL_ADD;
                    OPC_SUB: ctl_comb = CTL_SUB;
                    OPC_AND: ctl_comb = CTL_AND;
                    OPC_ORR: ctl_comb = CTL_ORR;
                    default: ctl_comb = CTL_ADD;
                endcase
            end
            default: ctl_comb = CTL_ADD;
        endcase
    end

    // ALU proper, wrapping arithmetic; codes without an operation give zero.
    always_comb begin
        result_comb = '0;
        case (ctl_comb)
            CTL_AND:  result_comb = operand_a & operand_b;
            CTL_ORR:  result_comb = operand_a | operand_b;
            CTL_ADD:  result_comb = operand_a + operand_b;
            CTL_SUB:  result_comb = operand_a - operand_b;
            CTL_PASS: result_comb = operand_b;
            CTL_NOR:  result_comb = ~(operand_a | operand_b);
            default:  result_comb = '0;
        endcase
    end

    // Address arithmetic and next-PC choice, all from this cycle's values.
    always_comb begin
        zero_comb     = (result_comb == '0);
        pc_plus4_comb = pc + WIDTH'(4);
        target_comb   = pc + (branch_offset << 2);
        next_pc_comb  = (branch && zero_comb) ? target_comb : pc_plus4_comb;
    end

    // Pipeline register: valid always follows the input, data only loads on valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            alu_ctl       <= '0;
            result        <= '0;
            zero          <= 1'b0;
            pc_plus4      <= '0;
            branch_target <= '0;
            next_pc       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_ctl       <= ctl_comb;
                result        <= result_comb;
                zero          <= zero_comb;
                pc_plus4      <= pc_plus4_comb;
                branch_target <= target_comb;
                next_pc       <= next_pc_comb;
            end
        end
    end

endmodule

// File: tb/tb_alu_execute_stage.sv
// tb_alu_execute_stage: directed self-checking bench for alu_execute_stage.
module tb_alu_execute_stage;

    localparam int WIDTH = 64;
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_BAD = 11'b11111111111;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [10:0]      opcode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] branch_offset;
    logic             branch;
    logic             out_valid;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] next_pc;

    int assert_count = 0;
    int fail_count   = 0;

    alu_execute_stage #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .alu_op        (alu_op),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .pc            (pc),
        .branch_offset (branch_offset),
        .branch        (branch),
        .out_valid     (out_valid),
        .alu_ctl       (alu_ctl),
        .result        (result),
        .zero          (zero),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .next_pc       (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic ev, input logic [3:0] ectl,
                            input logic [WIDTH-1:0] eres, input logic ez,
                            input logic [WIDTH-1:0] ep4, input logic [WIDTH-1:0] ebt,
                            input logic [WIDTH-1:0] enpc);
        checkOutput({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(ev));
        checkOutput({tag, ".alu_ctl"}, WIDTH'(alu_ctl), WIDTH'(ectl));
        checkOutput({tag, ".result"}, result, eres);
        checkOutput({tag, ".zero"}, WIDTH'(zero), WIDTH'(ez));
        checkOutput({tag, ".pc_plus4"}, pc_plus4, ep4);
        checkOutput({tag, ".branch_target"}, branch_target, ebt);
        checkOutput({tag, ".next_pc"}, next_pc, enpc);
    endtask

    // Drive one input set at the falling edge, then let one rising edge capture it.
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [10:0] opc,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] off,
                                 input logic br);
        @(negedge clk);
        in_valid      = v;
        alu_op        = op;
        opcode        = opc;
        operand_a     = a;
        operand_b     = b;
        pc            = p;
        branch_offset = off;
        branch        = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; alu_op = 2'b00; opcode = '0;
        operand_a = '0; operand_b = '0; pc = '0; branch_offset = '0; branch = 1'b0;
        #2;
        checkAll("reset", 1'b0, 4'h0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(1'b1, 2'b10, OPC_ADD, 64'd5, 64'd7, 64'h200, 64'd1, 1'b0);
        checkAll("add", 1'b1, 4'b0010, 64'd12, 1'b0, 64'h204, 64'h204, 64'h204);

        applyStimulus(1'b1, 2'b10, OPC_SUB, 64'd9, 64'd9, 64'h200, 64'd1, 1'b0);
        checkAll("sub_eq", 1'b1, 4'b0110, 64'd0, 1'b1, 64'h204, 64'h204, 64'h204);

        applyStimulus(1'b1, 2'b10, OPC_SUB, 64'd0, 64'd1, 64'h200, 64'd1, 1'b0);
        checkAll("sub_wrap", 1'b1, 4'b0110, ONES, 1'b0, 64'h204, 64'h204, 64'h204);

        applyStimulus(1'b1, 2'b01, OPC_BAD, 64'd77, 64'd0, 64'h100, 64'd3, 1'b1);
        checkAll("cbz_taken", 1'b1, 4'b0111, 64'd0, 1'b1, 64'h104, 64'h10C, 64'h10C);

        applyStimulus(1'b1, 2'b01, OPC_BAD, 64'd77, 64'd4, 64'h100, 64'd3, 1'b1);
        checkAll("cbz_not", 1'b1, 4'b0111, 64'd4, 1'b0, 64'h104, 64'h10C, 64'h104);

        applyStimulus(1'b1, 2'b10, OPC_SUB, 64'd3, 64'd3, 64'h100, 64'd3, 1'b0);
        checkAll("zero_nobranch", 1'b1, 4'b0110, 64'd0, 1'b1, 64'h104, 64'h10C, 64'h104);

        applyStimulus(1'b1, 2'b10, OPC_AND, 64'hF0, 64'h3C, 64'h40, 64'd0, 1'b0);
        checkAll("and", 1'b1, 4'b0000, 64'h30, 1'b0, 64'h44, 64'h40, 64'h44);

        applyStimulus(1'b1, 2'b10, OPC_ORR, 64'hF0, 64'h3C, 64'h40, 64'd0, 1'b0);
        checkAll("orr", 1'b1, 4'b0001, 64'hFC, 1'b0, 64'h44, 64'h40, 64'h44);

        applyStimulus(1'b1, 2'b10, OPC_BAD, 64'hF0, 64'h3C, 64'h40, 64'd0, 1'b0);
        checkAll("unknown_opc", 1'b1, 4'b0010, 64'h12C, 1'b0, 64'h44, 64'h40, 64'h44);

        applyStimulus(1'b1, 2'b11, OPC_SUB, 64'd100, 64'd28, 64'h40, 64'd0, 1'b0);
        checkAll("aluop11", 1'b1, 4'b0010, 64'd128, 1'b0, 64'h44, 64'h40, 64'h44);

        applyStimulus(1'b1, 2'b00, OPC_AND, 64'h1000, 64'h20, 64'h40, 64'd0, 1'b0);
        checkAll("ldst_add", 1'b1, 4'b0010, 64'h1020, 1'b0, 64'h44, 64'h40, 64'h44);

        applyStimulus(1'b1, 2'b01, OPC_ADD, 64'd1, 64'd0, ONES, 64'd0, 1'b1);
        checkAll("pc_wrap", 1'b1, 4'b0111, 64'd0, 1'b1, 64'd3, ONES, ONES);

        applyStimulus(1'b1, 2'b10, OPC_ADD, 64'd1, 64'd2, 64'h100, -64'sd2, 1'b0);
        checkAll("neg_offset", 1'b1, 4'b0010, 64'd3, 1'b0, 64'h104, 64'hF8, 64'h104);

        applyStimulus(1'b0, 2'b10, OPC_SUB, 64'd50, 64'd50, 64'h900, 64'd8, 1'b1);
        checkAll("hold", 1'b0, 4'b0010, 64'd3, 1'b0, 64'h104, 64'hF8, 64'h104);

        applyStimulus(1'b1, 2'b10, OPC_ORR, 64'h5, 64'hA, 64'h300, 64'd2, 1'b0);
        checkAll("resume", 1'b1, 4'b0001, 64'hF, 1'b0, 64'h304, 64'h308, 64'h304);

        // Pull reset between edges: outputs must clear without a clock edge.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'b00; operand_a = 64'd1; operand_b = 64'd1;
        #2;
        reset_n = 1'b0;
        #1;
        checkAll("async_reset", 1'b0, 4'h0, '0, 1'b0, '0, '0, '0);

        @(posedge clk);
        #1;
        checkAll("reset_held", 1'b0, 4'h0, '0, 1'b0, '0, '0, '0);

        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 2'b10, OPC_ADD, 64'd20, 64'd22, 64'h10, 64'd1, 1'b0);
        checkAll("post_reset", 1'b1, 4'b0010, 64'd42, 1'b0, 64'h14, 64'h14, 64'h14);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
